r2b_row_to_block_h: RTL and testbench

//  Row-to-block converter, horizontal core split. Takes a ROW x COL fixed-point matrix one row per beat.

---
 rtl/r2b_row_to_block_h.sv | 141 ++++++++++++++
 tb/tb_r2b_row_to_block_h.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2b_row_to_block_h.sv
// r2b_row_to_block_h: row-major matrix in, BLOCK_SIZE x BLOCK_SIZE tiles out,
// NUM_CORES_H tiles packed per output word (one tile per core).
// Optional build macro R2B_INDEX_OUT_EN adds out_blk_row / out_slice index outputs.
// Note: rst_n is a synchronous, active-HIGH reset despite its name.
module r2b_row_to_block_h #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC_WIDTH  = 8,
  parameter int unsigned ROW         = 12,
  parameter int unsigned COL         = 6,
  parameter int unsigned BLOCK_SIZE  = 2,
  parameter int unsigned CHUNK_SIZE  = 4,
  parameter int unsigned NUM_CORES_H = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      en,
  input  logic                                      in_valid,
  input  logic [WIDTH*COL-1:0]                      in_data,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H-1:0]   out_data,
`ifdef R2B_INDEX_OUT_EN
  output logic [($clog2(ROW/BLOCK_SIZE) > 0 ? $clog2(ROW/BLOCK_SIZE) : 1)-1:0] out_blk_row,
  output logic [($clog2(COL/(BLOCK_SIZE*NUM_CORES_H)) > 0 ? $clog2(COL/(BLOCK_SIZE*NUM_CORES_H)) : 1)-1:0] out_slice,
`endif
  output logic                                      output_ready,
  output logic                                      slice_last,
  output logic                                      buffer_done
);

  localparam int unsigned NSLICE  = COL / (BLOCK_SIZE * NUM_CORES_H);
  localparam int unsigned NBR     = ROW / BLOCK_SIZE;
  localparam int unsigned OUT_N   = CHUNK_SIZE * NUM_CORES_H;
  localparam int unsigned ROW_W   = WIDTH * COL;
  localparam int unsigned OUT_W   = WIDTH * OUT_N;
  localparam int unsigned RC_W    = ($clog2(BLOCK_SIZE) > 0) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned SL_W    = ($clog2(NSLICE) > 0) ? $clog2(NSLICE) : 1;
  localparam int unsigned BR_W    = ($clog2(NBR) > 0) ? $clog2(NBR) : 1;

  // Elaboration-time parameter sanity checks
  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_bad_chunk
    $error("CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
  end
  if (NSLICE == 0 || NSLICE > BLOCK_SIZE) begin : g_bad_nslice
    $error("NSLICE must be in 1..BLOCK_SIZE");
  end
  if (FRAC_WIDTH > WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must not exceed WIDTH");
  end

  // Ping-pong row storage: bank x row
  logic [ROW_W-1:0] row_buf [2][BLOCK_SIZE];

  logic              wr_bank;
  logic              rd_bank;
  logic [RC_W-1:0]   row_cnt;
  logic [SL_W-1:0]   slice_cnt;
  logic [BR_W-1:0]   blk_row;
  logic              pending;
  logic [OUT_W-1:0]  word_c;
  logic              row_last_c;
  logic              slice_last_c;
  logic              blk_last_c;

  assign row_last_c   = (row_cnt == RC_W'(BLOCK_SIZE - 1));
  assign slice_last_c = (slice_cnt == SL_W'(NSLICE - 1));
  assign blk_last_c   = (blk_row == BR_W'(NBR - 1));

  // Gather the tiles of the current slice from the read bank into one word
  for (genvar k = 0; k < NUM_CORES_H; k++) begin : g_core
    for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
      for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
        localparam int unsigned N = k * CHUNK_SIZE + r * BLOCK_SIZE + c;
        assign word_c[(OUT_N-1-N)*WIDTH +: WIDTH] =
          row_buf[rd_bank][r][(COL - 1 - ((32'(slice_cnt) * NUM_CORES_H + k) * BLOCK_SIZE + c)) * WIDTH +: WIDTH];
      end
    end
  end

  // Row capture into the write bank (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (!rst_n && en && in_valid) begin
      row_buf[wr_bank][row_cnt] <= in_data;
    end
  end

  // Capture bookkeeping, bank swap and slice emission
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      row_cnt      <= '0;
      slice_cnt    <= '0;
      blk_row      <= '0;
      pending      <= 1'b0;
      out_data     <= '0;
      output_ready <= 1'b0;
      slice_last   <= 1'b0;
      buffer_done  <= 1'b0;
`ifdef R2B_INDEX_OUT_EN
      out_blk_row  <= '0;
      out_slice    <= '0;
`endif
    end else begin
      output_ready <= 1'b0;
      slice_last   <= 1'b0;
      buffer_done  <= 1'b0;
      if (en) begin
        // Emit one slice of the queued bank
        if (pending) begin
          out_data     <= word_c;
          output_ready <= 1'b1;
          slice_last   <= slice_last_c;
          buffer_done  <= slice_last_c && blk_last_c;
`ifdef R2B_INDEX_OUT_EN
          out_blk_row  <= blk_row;
          out_slice    <= slice_cnt;
`endif
          if (slice_last_c) begin
            slice_cnt <= '0;
            pending   <= 1'b0;
            blk_row   <= blk_last_c ? '0 : blk_row + BR_W'(1);
          end else begin
            slice_cnt <= slice_cnt + SL_W'(1);
          end
        end
        // A completed bank takes precedence; emission of the old bank is done by now
        if (in_valid) begin
          if (row_last_c) begin
            row_cnt   <= '0;
            wr_bank   <= ~wr_bank;
            rd_bank   <= wr_bank;
            pending   <= 1'b1;
            slice_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + RC_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_r2b_row_to_block_h.sv
// Testbench for r2b_row_to_block_h: default instance (COL=6, one slice) and a
// COL=12 instance (two slices), checked against a tile-index reference model.
module tb_r2b_row_to_block_h;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en1, v1, en2, v2;
  logic [95:0]  d1;
  logic [191:0] d2;
  logic [191:0] o1, o2;
  logic         rdy1, last1, done1, rdy2, last2, done2;
`ifdef R2B_INDEX_OUT_EN
  logic [2:0]   br1;
  logic [0:0]   sl1;
  logic [2:0]   br2;
  logic [0:0]   sl2;
`endif

  r2b_row_to_block_h dut (
    .clk(clk), .rst_n(rst), .en(en1), .in_valid(v1), .in_data(d1),
    .out_data(o1),
`ifdef R2B_INDEX_OUT_EN
    .out_blk_row(br1), .out_slice(sl1),
`endif
    .output_ready(rdy1), .slice_last(last1), .buffer_done(done1)
  );

  r2b_row_to_block_h #(.COL(12)) dut2 (
    .clk(clk), .rst_n(rst), .en(en2), .in_valid(v2), .in_data(d2),
    .out_data(o2),
`ifdef R2B_INDEX_OUT_EN
    .out_blk_row(br2), .out_slice(sl2),
`endif
    .output_ready(rdy2), .slice_last(last2), .buffer_done(done2)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic en1_edge = 1'b1;
  logic en2_edge = 1'b1;

  int mat [24][12];

  logic [191:0] q1_data[$];
  bit           q1_last[$];
  bit           q1_done[$];
  int           q1_cyc[$];
  int           bad1 = 0;
  logic [191:0] q2_data[$];
  bit           q2_last[$];
  bit           q2_done[$];
  int           bad2 = 0;
  int           idx_bad = 0;
  int           w1 = 0;
  int           w2 = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    en1_edge <= en1;
    en2_edge <= en2;
  end

  // Output collector, sampled away from the active edge
  always @(negedge clk) begin
    if (rdy1) begin
      q1_data.push_back(o1); q1_last.push_back(last1);
      q1_done.push_back(done1); q1_cyc.push_back(cyc);
`ifdef R2B_INDEX_OUT_EN
      if (int'(br1) != (w1 % 6) || sl1 != 1'b0) idx_bad++;
`endif
      w1++;
    end
    if ((last1 || done1) && !rdy1) bad1++;
    if (rdy1 && !en1_edge) bad1++;
    if (rdy2) begin
      q2_data.push_back(o2); q2_last.push_back(last2); q2_done.push_back(done2);
`ifdef R2B_INDEX_OUT_EN
      if (int'(br2) != ((w2 / 2) % 6) || int'(sl2) != (w2 % 2)) idx_bad++;
`endif
      w2++;
    end
    if ((last2 || done2) && !rdy2) bad2++;
    if (rdy2 && !en2_edge) bad2++;
  end

  // Reference: element n of word (br, s) is tile k, row r, col c of the block-row
  function automatic logic [191:0] exp_word(int base, int br, int s);
    logic [191:0] w;
    int k, r, c;
    w = '0;
    for (int n = 0; n < 12; n++) begin
      k = n / 4; r = (n % 4) / 2; c = n % 2;
      w[(11-n)*16 +: 16] = 16'(mat[base + br*2 + r][(s*3 + k)*2 + c]);
    end
    return w;
  endfunction

  task automatic fill(input int rows, input bit pattern);
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < 12; j++)
        mat[i][j] = pattern ? (((i % 12) * 6 + j) << 8) & 32'hFFFF : int'($urandom & 32'hFFFF);
  endtask

  task automatic clear_q();
    q1_data.delete(); q1_last.delete(); q1_done.delete(); q1_cyc.delete();
    q2_data.delete(); q2_last.delete(); q2_done.delete();
    bad1 = 0; bad2 = 0; w1 = 0; w2 = 0;
  endtask

  task automatic set_row1(input int i);
    for (int j = 0; j < 6; j++) d1[(5-j)*16 +: 16] = 16'(mat[i][j]);
  endtask

  task automatic drive1(input int i);
    en1 = 1'b1; v1 = 1'b1; set_row1(i);
    @(posedge clk); #1;
  endtask

  task automatic idle1(input int n);
    v1 = 1'b0; d1 = {$urandom, $urandom, $urandom};
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_q1(input int n);
    int budget = 40;
    v1 = 1'b0;
    while (q1_data.size() < n && budget > 0) begin @(posedge clk); #1; budget--; end
    idle1(4);
  endtask

  task automatic test_reset;
    rst = 1'b1; en1 = 1'b1; v1 = 1'b0; en2 = 1'b1; v2 = 1'b0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (o1 !== '0) $display("FAIL reset_out_data got %h want 0", o1); else n_pass++;
    n_total++;
    if ({rdy1, last1, done1} !== 3'b000) $display("FAIL reset_flags got %b want 000", {rdy1, last1, done1}); else n_pass++;
    n_total++;
    if ({rdy2, last2, done2, o2} !== '0) $display("FAIL reset_dut2 got %b want 0", {rdy2, last2, done2}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_pattern;
    int cap;
    int lit[12] = '{0, 1, 6, 7, 2, 3, 8, 9, 4, 5, 10, 11};
    logic [191:0] w0;
    fill(12, 1'b1);
    clear_q();
    cap = 0;
    for (int i = 0; i < 12; i++) begin
      drive1(i);
      if (i == 1) cap = cyc;
    end
    wait_q1(6);
    n_total++;
    if (q1_data.size() != 6) $display("FAIL pattern_count got %0d want 6", q1_data.size()); else n_pass++;
    for (int i = 0; i < 12; i++) w0[(11-i)*16 +: 16] = 16'(lit[i] << 8);
    if (q1_data.size() > 0) begin
      n_total++;
      if (q1_data[0] !== w0) $display("FAIL pattern_word0 got %h want %h", q1_data[0], w0); else n_pass++;
      n_total++;
      if (q1_cyc[0] != cap + 1) $display("FAIL pattern_latency got %0d want %0d", q1_cyc[0], cap + 1); else n_pass++;
    end
    for (int w = 0; w < q1_data.size() && w < 6; w++) begin
      n_total++;
      if (q1_data[w] !== exp_word(0, w, 0)) $display("FAIL pattern_word%0d got %h want %h", w, q1_data[w], exp_word(0, w, 0)); else n_pass++;
      n_total++;
      if ({q1_last[w], q1_done[w]} !== {1'b1, w == 5}) $display("FAIL pattern_flags%0d got %b want %b", w, {q1_last[w], q1_done[w]}, {1'b1, w == 5}); else n_pass++;
    end
    n_total++;
    if (bad1 != 0) $display("FAIL pattern_stray_flags got %0d want 0", bad1); else n_pass++;
  endtask

  task automatic check_matrix1(input string name, input int base);
    n_total++;
    if (q1_data.size() != 6) $display("FAIL %s_count got %0d want 6", name, q1_data.size()); else n_pass++;
    for (int w = 0; w < q1_data.size() && w < 6; w++) begin
      n_total++;
      if (q1_data[w] !== exp_word(base, w, 0) || q1_done[w] !== (w == 5) || q1_last[w] !== 1'b1)
        $display("FAIL %s_word%0d got %h/%b%b want %h/1%b", name, w, q1_data[w], q1_last[w], q1_done[w], exp_word(base, w, 0), w == 5);
      else n_pass++;
    end
    n_total++;
    if (bad1 != 0) $display("FAIL %s_stray_flags got %0d want 0", name, bad1); else n_pass++;
  endtask

  task automatic test_reset_mid;
    fill(12, 1'b0);
    for (int i = 0; i < 3; i++) drive1(i);
    v1 = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_total++;
    if ({rdy1, last1, done1, o1} !== '0) $display("FAIL midreset_outputs got %b/%h want 0", {rdy1, last1, done1}, o1); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    fill(12, 1'b0);
    for (int i = 0; i < 12; i++) drive1(i);
    wait_q1(6);
    check_matrix1("midreset", 0);
  endtask

  task automatic test_stall;
    int cap5;
    fill(12, 1'b0);
    clear_q();
    for (int i = 0; i < 5; i++) drive1(i);
    en1 = 1'b0; v1 = 1'b1; set_row1(6);
    @(posedge clk); #1;
    drive1(5);
    cap5 = cyc;
    en1 = 1'b0; v1 = 1'b1; set_row1(7);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 6; i < 12; i++) drive1(i);
    wait_q1(6);
    check_matrix1("stall", 0);
    if (q1_cyc.size() > 2) begin
      n_total++;
      if (q1_cyc[2] != cap5 + 3) $display("FAIL stall_delay got %0d want %0d", q1_cyc[2], cap5 + 3); else n_pass++;
    end
  endtask

  task automatic test_valid_gaps;
    fill(12, 1'b0);
    clear_q();
    for (int i = 0; i < 12; i++) begin
      drive1(i);
      idle1(1);
    end
    wait_q1(6);
    check_matrix1("gaps", 0);
  endtask

  task automatic test_back_to_back;
    fill(24, 1'b0);
    clear_q();
    for (int i = 0; i < 24; i++) drive1(i);
    wait_q1(12);
    n_total++;
    if (q1_data.size() != 12) $display("FAIL b2b_count got %0d want 12", q1_data.size()); else n_pass++;
    for (int w = 0; w < q1_data.size() && w < 12; w++) begin
      n_total++;
      if (q1_data[w] !== exp_word((w / 6) * 12, w % 6, 0)) $display("FAIL b2b_word%0d got %h want %h", w, q1_data[w], exp_word((w / 6) * 12, w % 6, 0)); else n_pass++;
      n_total++;
      if (q1_done[w] !== (w == 5 || w == 11)) $display("FAIL b2b_done%0d got %b want %b", w, q1_done[w], (w == 5 || w == 11)); else n_pass++;
    end
  endtask

  task automatic test_two_slice;
    int budget = 60;
    fill(12, 1'b0);
    clear_q();
    for (int i = 0; i < 12; i++) begin
      en2 = 1'b1; v2 = 1'b1;
      for (int j = 0; j < 12; j++) d2[(11-j)*16 +: 16] = 16'(mat[i][j]);
      @(posedge clk); #1;
    end
    v2 = 1'b0;
    while (q2_data.size() < 12 && budget > 0) begin @(posedge clk); #1; budget--; end
    repeat (4) begin @(posedge clk); #1; end
    n_total++;
    if (q2_data.size() != 12) $display("FAIL slice2_count got %0d want 12", q2_data.size()); else n_pass++;
    for (int w = 0; w < q2_data.size() && w < 12; w++) begin
      n_total++;
      if (q2_data[w] !== exp_word(0, w / 2, w % 2)) $display("FAIL slice2_word%0d got %h want %h", w, q2_data[w], exp_word(0, w / 2, w % 2)); else n_pass++;
      n_total++;
      if ({q2_last[w], q2_done[w]} !== {(w % 2) == 1, w == 11}) $display("FAIL slice2_flags%0d got %b want %b", w, {q2_last[w], q2_done[w]}, {(w % 2) == 1, w == 11}); else n_pass++;
    end
    n_total++;
    if (bad2 != 0) $display("FAIL slice2_stray_flags got %0d want 0", bad2); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern();
    test_reset_mid();
    test_stall();
    test_valid_gaps();
    test_back_to_back();
    test_two_slice();
`ifdef R2B_INDEX_OUT_EN
    n_total++;
    if (idx_bad != 0) $display("FAIL index_outputs got %0d bad want 0", idx_bad); else n_pass++;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
